// File: rtl/tile_step_issuer_if.sv
// Job/step handshake bundle between a job source, tile_step_issuer and the downstream step counter.
// Gap-control field is present only when TILE_STEP_GAP_EN is defined.
`ifndef SA_NUM
`define SA_NUM 16
`endif

interface tile_step_issuer_if #(
    parameter int BIT_WIDTH = $clog2(`SA_NUM) + 4
`ifdef TILE_STEP_GAP_EN
    , parameter int GAP_W = 4
`endif
);
    logic                 job_valid;
    logic                 job_ready;
    logic [BIT_WIDTH-1:0] job_max;
    logic                 abort;
    logic                 step_ready;
    logic                 inc;
    logic [BIT_WIDTH-1:0] step_idx;
    logic                 last;
    logic                 busy;
    logic                 done;
`ifdef TILE_STEP_GAP_EN
    logic [GAP_W-1:0]     gap_cycles;

    modport master (
        output job_valid, job_max, abort, step_ready, gap_cycles,
        input  job_ready, inc, step_idx, last, busy, done
    );
    modport slave (
        input  job_valid, job_max, abort, step_ready, gap_cycles,
        output job_ready, inc, step_idx, last, busy, done
    );
`else
    modport master (
        output job_valid, job_max, abort, step_ready,
        input  job_ready, inc, step_idx, last, busy, done
    );
    modport slave (
        input  job_valid, job_max, abort, step_ready,
        output job_ready, inc, step_idx, last, busy, done
    );
`endif
endinterface

// File: rtl/tile_step_issuer.sv
// Issues job_max+1 inc pulses per job, shadowing the downstream wrap-at-max counter index.
// Latency: first inc the cycle after accept, then 1/cycle; one DONE bubble between jobs.
// Backpressure: inc waits on step_ready; abort cancels at once. TILE_STEP_GAP_EN adds idle gaps.
`ifndef SA_NUM
`define SA_NUM 16
`endif

module tile_step_issuer #(
    parameter int BIT_WIDTH = $clog2(`SA_NUM) + 4
`ifdef TILE_STEP_GAP_EN
    , parameter int GAP_W = 4
`endif
) (
    input  logic               clk,
    input  logic               rstn,
    tile_step_issuer_if.slave  bus
);

`ifdef TILE_STEP_GAP_EN
    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    state_t               state, state_n;
    logic [BIT_WIDTH-1:0] step_idx, idx_n;
    logic [BIT_WIDTH-1:0] max_q, max_n;
`ifdef TILE_STEP_GAP_EN
    logic [GAP_W-1:0]     gap_q, gap_q_n;
    logic [GAP_W-1:0]     gap_cnt, cnt_n;
`endif
    logic                 job_ready_c;
    logic                 inc_c;
    logic                 last_c;
    logic                 done_c;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            step_idx <= '0;
            max_q    <= '0;
`ifdef TILE_STEP_GAP_EN
            gap_q    <= '0;
            gap_cnt  <= '0;
`endif
        end else begin
            state    <= state_n;
            step_idx <= idx_n;
            max_q    <= max_n;
`ifdef TILE_STEP_GAP_EN
            gap_q    <= gap_q_n;
            gap_cnt  <= cnt_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = step_idx;
        max_n       = max_q;
`ifdef TILE_STEP_GAP_EN
        gap_q_n     = gap_q;
        cnt_n       = gap_cnt;
`endif
        job_ready_c = 1'b0;
        inc_c       = 1'b0;
        last_c      = 1'b0;
        done_c      = 1'b0;

        case (state)
            IDLE: begin
                job_ready_c = !bus.abort;
                if (bus.job_valid && job_ready_c) begin
                    max_n   = bus.job_max;
                    idx_n   = '0;
`ifdef TILE_STEP_GAP_EN
                    gap_q_n = bus.gap_cycles;
`endif
                    state_n = RUN;
                end
            end
            RUN: begin
                inc_c  = bus.step_ready && !bus.abort;
                last_c = inc_c && (step_idx == max_q);
                if (inc_c) begin
                    // The final step keeps its index so step_idx matches the counter at overflow.
                    if (last_c) begin
                        state_n = DONE;
                    end else begin
                        idx_n = step_idx + BIT_WIDTH'(1);
`ifdef TILE_STEP_GAP_EN
                        if (gap_q != '0) begin
                            cnt_n   = gap_q;
                            state_n = GAP;
                        end
`endif
                    end
                end
            end
`ifdef TILE_STEP_GAP_EN
            GAP: begin
                cnt_n = gap_cnt - GAP_W'(1);
                if (gap_cnt <= GAP_W'(1)) state_n = RUN;
            end
`endif
            DONE: begin
                done_c  = !bus.abort;
                idx_n   = '0;
                state_n = IDLE;
            end
            default: begin
                idx_n   = '0;
                state_n = IDLE;
            end
        endcase

        // Abort outranks accept, step and done in every state.
        if (bus.abort) begin
            state_n = IDLE;
            idx_n   = '0;
        end
    end

    assign bus.job_ready = job_ready_c;
    assign bus.inc       = inc_c;
    assign bus.last      = last_c;
    assign bus.done      = done_c;
    assign bus.busy      = (state != IDLE);
    assign bus.step_idx  = step_idx;

endmodule
